// File: rtl/hamming_enc_scheduler.sv
// hamming_enc_scheduler: round-robin time-sharing of one external Hamming encoder among NUM_REQ requesters
module hamming_enc_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ENC_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           enc_data_in,
  input  logic [7:0]           enc_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_code,
  output logic [ID_W-1:0]      out_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     code_count
);
  localparam int CW = $clog2(ENC_LAT + 2);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, g;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] nib_q, nib_d;
  logic [7:0] code_q, code_d;
  logic ov_q, ov_d, found;
  logic [CNT_W-1:0] code_count_q, code_count_d;
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        g = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    nib_d = nib_q;
    code_d = code_q;
    ov_d = ov_q;
    code_count_d = code_count_q;
    req_ready = '0;
    case (state_q)
      IDLE: if (found && rstn) begin
        req_ready[g] = 1'b1;
        nib_d = req_data[4*g +: 4];
        ptr_d = g;
        cnt_d = CW'(ENC_LAT + 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          code_d = enc_data_out;
          id_d = ptr_q;
          ov_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: if (out_ready) begin
        ov_d = 1'b0;
        code_count_d = code_count_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      cnt_q <= '0;
      nib_q <= '0;
      code_q <= '0;
      ov_q <= 1'b0;
      code_count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      nib_q <= nib_d;
      code_q <= code_d;
      ov_q <= ov_d;
      code_count_q <= code_count_d;
    end
  end
  assign enc_data_in = nib_q;
  assign out_valid = ov_q;
  assign out_code = code_q;
  assign out_id = id_q;
  assign busy = state_q != IDLE;
  assign code_count = code_count_q;
endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// tb_hamming_enc_scheduler: scoreboard bench with directed vectors for hamming_enc_scheduler
module tb_hamming_enc_scheduler;
  logic clk = 1'b0, rstn = 1'b0, out_ready = 1'b0;
  logic [3:0] req_valid = '0, req_ready, enc_data_in;
  logic [15:0] req_data = '0, code_count;
  logic [7:0] enc_data_out = '0, out_code;
  logic [1:0] out_id;
  logic out_valid, busy;
  int checks = 0, errs = 0, xfers = 0;
  logic [9:0] sb[$];
  hamming_enc_scheduler dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enc_data_in(enc_data_in), .enc_data_out(enc_data_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_code(out_code), .out_id(out_id), .busy(busy), .code_count(code_count)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ham(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
    return {^c, c};
  endfunction
  always @(posedge clk) enc_data_out <= ham(enc_data_in);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [9:0] e;
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 32'(out_code), 32'hdead);
      else begin
        e = sb.pop_front();
        chk("out_code", 32'(out_code), 32'(e[9:2]));
        chk("out_id", 32'(out_id), 32'(e[1:0]));
      end
      xfers++;
    end
    if (|req_ready) begin
      chk("grant_onehot", $countones(req_ready), 1);
      chk("grant_valid", 32'(req_ready & ~req_valid), 0);
    end
  end
  task automatic issue(input logic [3:0] v, input logic [15:0] d, input logic [7:0] code, input logic [1:0] id);
    int n;
    @(posedge clk); #1;
    sb.push_back({code, id});
    req_valid = v;
    req_data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!(|req_ready) && n < 20);
    chk("grant", 32'(req_ready), 32'(4'b0001 << id));
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk("latency", n, 3);
    if (out_ready) begin
      n = 0;
      do begin @(negedge clk); n++; end while (busy && n < 20);
      chk("return_idle", 32'(busy), 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(code_count), 0);
    chk("rst_enc_in", 32'(enc_data_in), 0);
    chk("rst_code", 32'(out_code), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    out_ready = 1'b1;
    issue(4'b0100, 16'h0000, 8'h00, 2'd2);
    issue(4'b0100, 16'h0F00, 8'hFF, 2'd2);
    issue(4'b0100, 16'h0100, 8'h87, 2'd2);
    chk("codes_count", 32'(code_count), 3);
    issue(4'b0001, 16'h000B, 8'h55, 2'd0);
    chk("single_count", 32'(code_count), 4);
    out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data = 16'h000F;
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk("hold_reached", 32'(out_valid), 1);
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("hrst_out_valid", 32'(out_valid), 0);
    chk("hrst_busy", 32'(busy), 0);
    chk("hrst_count", 32'(code_count), 0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("hrst_discard", 32'(out_valid), 0);
    sb.push_back({8'h00, 2'd0});
    sb.push_back({8'h87, 2'd1});
    sb.push_back({8'h99, 2'd2});
    sb.push_back({8'h1E, 2'd3});
    sb.push_back({8'h00, 2'd0});
    @(posedge clk); #1;
    req_valid = 4'b1111;
    req_data = 16'h3210;
    n = xfers + 5;
    for (int i = 0; i < 100 && xfers < n; i++) @(posedge clk);
    #1 req_valid = '0;
    chk("rr_xfers", xfers, n);
    @(negedge clk);
    chk("rr_count", 32'(code_count), 5);
    out_ready = 1'b0;
    issue(4'b0010, 16'h00B0, 8'h55, 2'd1);
    req_valid = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_code", 32'(out_code), 32'h55);
      chk("bp_id", 32'(out_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_released", 32'(out_valid), 0);
    chk("bp_count", 32'(code_count), 6);
    @(posedge clk); #1;
    force dut.code_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.code_count_q;
    issue(4'b1000, 16'h0000, 8'h00, 2'd3);
    chk("wrap_count", 32'(code_count), 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
